// File: rtl/melody_chime_seq.sv
// Score sequencer for the chime sound generator.
// Walks a synchronous score ROM from address 0. For each note word it
// aligns to the 1 ms clock enable and writes DIV/note-on to the generator
// for exactly one millisecond. It then holds until the note has lasted
// LEN tempo ticks, and moves on to the next word.
// Playback ends on an END word, or after the last ROM address has played.
// In both cases DONE_o pulses once.
module melody_chime_seq #(
   parameter int C_ADR_W   = 6,    // score address width; depth = 2**C_ADR_W
   parameter int C_TICK_MS = 125   // tempo tick length in ms (1..1023)
) (
   input  logic               CK_i,
   input  logic               XARST_i,
   input  logic               EE_1KHZ_i,
   input  logic               START_i,
   input  logic               STOP_i,
   output logic [C_ADR_W-1:0] SCORE_ADRs_o,
   input  logic [15:0]        SCORE_DATs_i,
   output logic [7:0]         DIV_LENs_o,
   output logic               SOUND_ON_o,
   output logic               WE_o,
   output logic               BUSY_o,
   output logic               DONE_o
);

   localparam int C_MS_W = $clog2(C_TICK_MS + 1);

   typedef enum logic [2:0] {
      S_IDLE,    // waiting for START_i
      S_FETCH,   // address presented, ROM read in flight
      S_DECODE,  // ROM word valid, latch it
      S_ARM,     // wait for a 1 ms enable to align the note onset
      S_ISSUE,   // generator write strobe, lasts one full millisecond
      S_HOLD     // count remaining milliseconds of the note
   } state_t;

   state_t             state_q, state_d;
   logic [C_ADR_W-1:0] adr_q, adr_d;
   logic               rest_q, rest_d;
   logic [5:0]         len_q, len_d;
   logic [7:0]         note_div_q, note_div_d;
   logic [7:0]         div_q, div_d;
   logic [C_MS_W-1:0]  ms_q, ms_d;
   logic [5:0]         tick_q, tick_d;
   logic               done_q, done_d;

   logic [5:0]         len_eff;
   logic               ms_wrap;
   logic               note_end;
   logic               last_adr;

   // A LEN of zero plays as a single tick rather than a silent skip.
   assign len_eff  = (len_q == 6'd0) ? 6'd1 : len_q;
   // This millisecond closes the current tempo tick.
   assign ms_wrap  = (ms_q == C_MS_W'(C_TICK_MS - 1));
   // This millisecond closes the last tick of the note.
   assign note_end = ms_wrap && ((tick_q + 6'd1) == len_eff);
   // The last ROM word has no successor, so the score stops instead of wrapping.
   assign last_adr = (adr_q == {C_ADR_W{1'b1}});

   // Next-state, address, note latch and timing counters.
   always_comb begin
      // NOTE: every variable gets a default before any branch, so that no
      // path leaves it unassigned and no latch is inferred.
      state_d    = state_q;
      adr_d      = adr_q;
      rest_d     = rest_q;
      len_d      = len_q;
      note_div_d = note_div_q;
      div_d      = div_q;
      ms_d       = ms_q;
      tick_d     = tick_q;
      done_d     = 1'b0;

      if (STOP_i) begin
         // An abort beats every other event, START_i included.
         // It issues no DONE and keeps DIV_LENs_o.
         state_d = S_IDLE;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               if (START_i) begin
                  adr_d   = '0;
                  state_d = S_FETCH;
               end
            end

            S_FETCH: state_d = S_DECODE;

            S_DECODE: begin
               rest_d     = SCORE_DATs_i[14];
               len_d      = SCORE_DATs_i[13:8];
               note_div_d = SCORE_DATs_i[7:0];
               if (SCORE_DATs_i[15]) begin
                  state_d = S_IDLE;
                  done_d  = 1'b1;
               end else begin
                  state_d = S_ARM;
               end
            end

            S_ARM: begin
               if (EE_1KHZ_i) begin
                  ms_d    = '0;
                  tick_d  = '0;
                  state_d = S_ISSUE;
                  // A rest leaves the generator's divider untouched.
                  if (!rest_q) begin
                     div_d = note_div_q;
                  end
               end
            end

            // The enable that closes ISSUE is already ms 1 of the note.
            // Both states therefore share the counting path.
            S_ISSUE, S_HOLD: begin
               if (EE_1KHZ_i) begin
                  if (ms_wrap) begin
                     ms_d   = '0;
                     tick_d = tick_q + 6'd1;
                  end else begin
                     ms_d   = ms_q + C_MS_W'(1);
                  end
                  if (note_end) begin
                     if (last_adr) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                     end else begin
                        adr_d   = adr_q + C_ADR_W'(1);
                        state_d = S_FETCH;
                     end
                  end else begin
                     state_d = S_HOLD;
                  end
               end
            end

            default: state_d = S_IDLE;
         endcase
      end
   end

   // State and datapath registers; reset returns everything to idle zeros.
   always_ff @(posedge CK_i or negedge XARST_i) begin
      if (!XARST_i) begin
         state_q    <= S_IDLE;
         adr_q      <= '0;
         rest_q     <= 1'b0;
         len_q      <= '0;
         note_div_q <= '0;
         div_q      <= '0;
         ms_q       <= '0;
         tick_q     <= '0;
         done_q     <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments let all registers update together
         // from the values of the previous cycle.
         state_q    <= state_d;
         adr_q      <= adr_d;
         rest_q     <= rest_d;
         len_q      <= len_d;
         note_div_q <= note_div_d;
         div_q      <= div_d;
         ms_q       <= ms_d;
         tick_q     <= tick_d;
         done_q     <= done_d;
      end
   end

   // The write strobe and note-on follow the ISSUE state directly.
   // A STOP_i or reset therefore removes them on the next edge.
   assign WE_o         = (state_q == S_ISSUE);
   assign SOUND_ON_o   = (state_q == S_ISSUE) && !rest_q;
   assign BUSY_o       = (state_q != S_IDLE);
   assign DONE_o       = done_q;
   assign DIV_LENs_o   = div_q;
   assign SCORE_ADRs_o = adr_q;

endmodule

// File: tb/tb_melody_chime_seq.sv
// Self-checking bench for melody_chime_seq (4-word score, 4 ms tick).
// The reference model walks the score as a sequential program: fetch,
// align, strobe for 1 ms, count N*T ms, next. A negedge compare process
// checks every DUT output against it on every cycle. Directed scenarios add
// hand-computed checks on strobe length, onset spacing and done counts.
module tb_melody_chime_seq;

   localparam int C_ADR_W   = 2;
   localparam int C_TICK_MS = 4;
   localparam int DEPTH     = 4;
   localparam int EE_P      = 4;   // clock cycles per simulated millisecond

   logic               CK_i      = 1'b0;
   logic               XARST_i   = 1'b0;
   logic               EE_1KHZ_i = 1'b0;
   logic               START_i   = 1'b0;
   logic               STOP_i    = 1'b0;
   logic [C_ADR_W-1:0] SCORE_ADRs_o;
   logic [15:0]        SCORE_DATs_i = 16'h0000;
   logic [7:0]         DIV_LENs_o;
   logic               SOUND_ON_o;
   logic               WE_o;
   logic               BUSY_o;
   logic               DONE_o;

   melody_chime_seq #(.C_ADR_W(C_ADR_W), .C_TICK_MS(C_TICK_MS)) dut (
      .CK_i        (CK_i),
      .XARST_i     (XARST_i),
      .EE_1KHZ_i   (EE_1KHZ_i),
      .START_i     (START_i),
      .STOP_i      (STOP_i),
      .SCORE_ADRs_o(SCORE_ADRs_o),
      .SCORE_DATs_i(SCORE_DATs_i),
      .DIV_LENs_o  (DIV_LENs_o),
      .SOUND_ON_o  (SOUND_ON_o),
      .WE_o        (WE_o),
      .BUSY_o      (BUSY_o),
      .DONE_o      (DONE_o)
   );

   always #5 CK_i = ~CK_i;

   // Synchronous score ROM: the word appears one cycle after its address.
   logic [15:0] rom [DEPTH] = '{default: 16'h0000};
   always @(posedge CK_i) SCORE_DATs_i <= rom[SCORE_ADRs_o];

   // The 1 ms enable: one cycle high every EE_P cycles.
   initial begin
      forever begin
         repeat (EE_P - 1) @(negedge CK_i);
         EE_1KHZ_i = 1'b1;
         @(negedge CK_i);
         EE_1KHZ_i = 1'b0;
      end
   end

   int n_cmp  = 0;
   int n_fail = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   logic [C_ADR_W-1:0] m_adr  = '0;
   logic [7:0]         m_div  = '0;
   logic               m_we   = 1'b0;
   logic               m_son  = 1'b0;
   logic               m_busy = 1'b0;
   logic               m_done = 1'b0;
   bit                 m_ab;

   task automatic model_clear();
      m_adr = '0; m_div = '0; m_we = 0; m_son = 0; m_busy = 0; m_done = 0;
   endtask

   // One clock of model time. An abort is a STOP_i or a reset seen at that edge.
   task automatic tick_m(output bit ab);
      @(posedge CK_i or negedge XARST_i);
      ab = !XARST_i || STOP_i;
   endtask

   // Plays the whole score as a program. It returns early on an abort.
   task automatic play(output bit ab);
      logic [15:0] w;
      int need, got;
      ab = 0;
      for (int a = 0; a < DEPTH; a++) begin
         m_adr  = C_ADR_W'(a);
         m_busy = 1;
         repeat (2) begin
            tick_m(ab);
            if (ab) return;
         end
         w = rom[a];
         if (w[15]) break;
         do begin tick_m(ab); if (ab) return; end while (!EE_1KHZ_i);
         m_we  = 1;
         m_son = !w[14];
         if (!w[14]) m_div = w[7:0];
         need = ((w[13:8] == 6'd0) ? 1 : int'(w[13:8])) * C_TICK_MS;
         do begin tick_m(ab); if (ab) return; end while (!EE_1KHZ_i);
         got  = 1;
         m_we = 0; m_son = 0;
         while (got < need) begin
            tick_m(ab);
            if (ab) return;
            if (EE_1KHZ_i) got++;
         end
      end
      m_busy = 0; m_we = 0; m_son = 0; m_done = 1;
      tick_m(ab);
      if (ab) return;
      m_done = 0;
   endtask

   initial begin
      forever begin
         @(posedge CK_i or negedge XARST_i);
         if (!XARST_i) begin
            model_clear();
         end else if (START_i && !STOP_i) begin
            play(m_ab);
            if (!XARST_i) model_clear();
            else if (m_ab) begin
               m_we = 0; m_son = 0; m_busy = 0; m_done = 0;
            end
         end
      end
   end

   // Every-cycle comparison against the model.
   initial begin
      forever begin
         @(negedge CK_i);
         check("we",   WE_o,         m_we);
         check("son",  SOUND_ON_o,   m_son);
         check("div",  DIV_LENs_o,   m_div);
         check("adr",  SCORE_ADRs_o, m_adr);
         check("busy", BUSY_o,       m_busy);
         check("done", DONE_o,       m_done);
      end
   end

   // Event monitor for the hand-computed checks.
   int          cyc = 0;
   int          we_cycles = 0;
   int          done_cnt = 0;
   logic        we_prev = 1'b0;
   int          on_cyc[$];
   logic        on_son[$];
   logic [7:0]  on_div[$];

   initial begin
      forever begin
         @(negedge CK_i);
         cyc++;
         if (WE_o) we_cycles++;
         if (WE_o && !we_prev) begin
            on_cyc.push_back(cyc);
            on_son.push_back(SOUND_ON_o);
            on_div.push_back(DIV_LENs_o);
         end
         we_prev = WE_o;
         if (DONE_o) done_cnt++;
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic start_pulse();
      @(negedge CK_i); START_i = 1'b1;
      @(negedge CK_i); START_i = 1'b0;
   endtask

   task automatic wait_idle(input int max, input string tag);
      int n = 0;
      while (BUSY_o && n < max) begin @(negedge CK_i); n++; end
      check({tag, "_idle_timeout"}, BUSY_o, 1'b0);
      repeat (2) @(negedge CK_i);
   endtask

   task automatic wait_onsets(input int k, input int max, input string tag);
      int n = 0;
      while (on_cyc.size() < k && n < max) begin @(negedge CK_i); n++; end
      check({tag, "_onset_timeout"}, (on_cyc.size() >= k), 1'b1);
   endtask

   task automatic clear_log();
      on_cyc.delete(); on_son.delete(); on_div.delete();
      we_cycles = 0;
   endtask

   task automatic do_reset();
      @(negedge CK_i); XARST_i = 1'b0;
      repeat (2) @(negedge CK_i);
      XARST_i = 1'b1;
   endtask

   int d0;

   initial begin
      repeat (3) @(negedge CK_i);
      XARST_i = 1'b1;
      @(negedge CK_i);
      check("rst_busy", BUSY_o, 0);
      check("rst_adr",  SCORE_ADRs_o, 0);
      check("rst_div",  DIV_LENs_o, 0);

      // T1: one 2-tick note, then END.
      rom = '{16'h0214, 16'h8000, 16'h0000, 16'h0000};
      clear_log(); d0 = done_cnt;
      start_pulse();
      wait_idle(400, "t1");
      check("t1_onsets",  on_cyc.size(), 1);
      check("t1_we_len",  we_cycles, EE_P);
      if (on_cyc.size() >= 1) begin
         check("t1_son", on_son[0], 1);
         check("t1_div", on_div[0], 20);
      end
      check("t1_done", done_cnt - d0, 1);
      check("t1_adr",  SCORE_ADRs_o, 1);

      // T2: rest then note, from a fresh reset.
      do_reset();
      rom = '{16'h41AA, 16'h0132, 16'h8000, 16'h0000};
      clear_log();
      start_pulse();
      wait_idle(400, "t2");
      check("t2_onsets", on_cyc.size(), 2);
      if (on_cyc.size() >= 2) begin
         check("t2_son0", on_son[0], 0);
         check("t2_div0", on_div[0], 0);
         check("t2_son1", on_son[1], 1);
         check("t2_div1", on_div[1], 50);
         check("t2_spacing", on_cyc[1] - on_cyc[0], 20);
      end

      // T3: LEN=0 is timed as one tick.
      rom = '{16'h0007, 16'h0109, 16'h8000, 16'h0000};
      clear_log();
      start_pulse();
      wait_idle(400, "t3");
      check("t3_onsets", on_cyc.size(), 2);
      if (on_cyc.size() >= 2) check("t3_len0_spacing", on_cyc[1] - on_cyc[0], 20);

      // T4: STOP_i mid-HOLD of the second note, then restart.
      rom = '{16'h011E, 16'h031F, 16'h8000, 16'h0000};
      clear_log(); d0 = done_cnt;
      start_pulse();
      wait_onsets(2, 200, "t4");
      repeat (10) @(negedge CK_i);
      check("t4_hold_adr",  SCORE_ADRs_o, 1);
      check("t4_hold_busy", BUSY_o, 1);
      STOP_i = 1'b1;
      @(negedge CK_i); STOP_i = 1'b0;
      check("t4_stop_busy", BUSY_o, 0);
      check("t4_stop_we",   WE_o, 0);
      check("t4_stop_div",  DIV_LENs_o, 31);
      d0 = done_cnt;
      begin
         int wc;
         wc = we_cycles;
         repeat (60) @(negedge CK_i);
         check("t4_no_done", done_cnt - d0, 0);
         check("t4_no_we",   we_cycles - wc, 0);
      end
      start_pulse();
      check("t4_restart_busy", BUSY_o, 1);
      check("t4_restart_adr",  SCORE_ADRs_o, 0);
      wait_idle(400, "t4");

      // T5: no END word; all four notes play, and START_i during play is ignored.
      rom = '{16'h010B, 16'h010C, 16'h010D, 16'h010E};
      clear_log(); d0 = done_cnt;
      start_pulse();
      wait_onsets(2, 200, "t5");
      start_pulse();
      wait_idle(400, "t5");
      check("t5_onsets", on_cyc.size(), 4);
      if (on_cyc.size() >= 4) begin
         check("t5_spacing", on_cyc[3] - on_cyc[0], 60);
         check("t5_div3",    on_div[3], 14);
      end
      check("t5_done", done_cnt - d0, 1);
      check("t5_adr",  SCORE_ADRs_o, 3);
      repeat (40) @(negedge CK_i);
      check("t5_no_replay", on_cyc.size(), 4);

      // T6: START_i together with STOP_i in IDLE is ignored.
      @(negedge CK_i); START_i = 1'b1; STOP_i = 1'b1;
      @(negedge CK_i); START_i = 1'b0; STOP_i = 1'b0;
      check("t6_busy", BUSY_o, 0);
      check("t6_adr",  SCORE_ADRs_o, 3);
      repeat (5) @(negedge CK_i);
      check("t6_still_idle", BUSY_o, 0);

      // T7: asynchronous reset in the middle of ISSUE.
      clear_log();
      start_pulse();
      wait_onsets(1, 200, "t7");
      check("t7_in_issue", WE_o, 1);
      #2 XARST_i = 1'b0;
      #1;
      check("t7_rst_we",   WE_o, 0);
      check("t7_rst_son",  SOUND_ON_o, 0);
      check("t7_rst_busy", BUSY_o, 0);
      check("t7_rst_div",  DIV_LENs_o, 0);
      check("t7_rst_adr",  SCORE_ADRs_o, 0);
      check("t7_rst_done", DONE_o, 0);
      repeat (2) @(negedge CK_i);
      XARST_i = 1'b1;
      repeat (4) @(negedge CK_i);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   // Last-resort bound on total run time.
   initial begin
      #400000;
      $display("FAIL watchdog: run did not end (compared %0d)", n_cmp);
      $fatal(1);
   end

endmodule

// File: doc/melody_chime_seq.md
Name: melody_chime_seq

Overview:
- Score sequencer directly upstream of the chime sound generator.
- Fetches note words from a synchronous score ROM and drives the generator's register write port (divider length, note-on, write enable).
- Times each note in units of a tempo tick derived from the 1 ms clock enable.
- Provides start/stop control and busy/done status to the system controller.

Parameters:
C_ADR_W, 6, score address width; depth = 2**C_ADR_W words
C_TICK_MS, 125, tempo tick length in ms (1..1023)

Ports:
CK_i  in  1  system clock
XARST_i  in  1  reset, asynchronous, active-low
EE_1KHZ_i  in  1  clock enable, 1 ms period, 1-cycle high pulse
START_i  in  1  start playback at address 0; honoured only in IDLE
STOP_i  in  1  abort playback, any state
SCORE_ADRs_o  out  C_ADR_W  score ROM address
SCORE_DATs_i  in  16  score word, valid 1 cycle after address: [15]=END, [14]=REST, [13:8]=LEN ticks, [7:0]=DIV
DIV_LENs_o  out  8  to generator DIV_LENs_i
SOUND_ON_o  out  1  to generator SOUND_ON_i
WE_o  out  1  to generator WE_i
BUSY_o  out  1  high while not IDLE
DONE_o  out  1  1-cycle pulse on natural score end

Behaviour:
- Reset values: all outputs 0, ADR=0, state IDLE.
- States and transitions:
  - IDLE --START_i--> FETCH: ADR=0.
  - FETCH (1 cycle) -> DECODE: ROM latency.
  - DECODE: latch word.
    - END=1: -> IDLE; DONE_o pulses in the cycle after DECODE; no WE.
    - Otherwise: -> ARM.
  - ARM: wait for EE_1KHZ_i. On that cycle -> ISSUE; clear ms/tick counters.
  - ISSUE:
    - WE_o=1, SOUND_ON_o=~REST, DIV_LENs_o=DIV (REST: DIV_LENs_o keeps previous value).
    - Held from the cycle after the arming pulse through and including the cycle of the next EE_1KHZ_i pulse. The generator's registered note-on therefore overlaps one EE_1KHZ_i cycle, so the envelope always retriggers.
    - That pulse counts as ms 1 of the note -> HOLD.
  - HOLD: WE_o=0. Counts EE_1KHZ_i pulses until the total note time reaches N_eff*C_TICK_MS ms, where N_eff = LEN, or 1 if LEN=0. Then:
    - ADR = last address (2**C_ADR_W - 1): -> IDLE, with DONE_o as for END.
    - Otherwise: ADR+1, -> FETCH.
- Note duration, measured from the start of WE_o to the next note's WE_o start: N_eff*C_TICK_MS ms plus at most 1 ms of ARM alignment.
- Counters: ms counter is $clog2(C_TICK_MS+1) bits; tick counter is 6 bits. No wrap inside a note.
- STOP_i:
  - Any state -> IDLE next cycle. WE_o, SOUND_ON_o, BUSY_o drop to 0. No DONE_o.
  - If in ISSUE, WE_o is cut short (note may not retrigger; acceptable).
  - DIV_LENs_o holds its value.
- STOP_i and START_i in the same cycle: STOP_i wins; remains IDLE.
- START_i while busy: ignored.
- START_i in the same cycle DONE_o is generated: ignored; a new START_i is needed after IDLE is reached.
- EE_1KHZ_i during FETCH/DECODE: not counted. Timing begins at ARM.
- Reset mid-operation: immediate return to reset values.
- SCORE_ADRs_o is a register and changes only on the FETCH entry edge.

Test Plan:
- Score {DIV=20,LEN=2}, {END}, C_TICK_MS=4, START -> ADR 0 then 1. One WE_o burst, 1 ms long, SOUND_ON_o=1, DIV_LENs_o=20. 8 ms later ADR=1 fetched; DONE_o pulses once; BUSY_o falls.
- Score {REST,LEN=1}, {DIV=50,LEN=1}, {END} -> first WE_o has SOUND_ON_o=0 and DIV_LENs_o=0. Second WE_o has DIV_LENs_o=50. Note onsets C_TICK_MS ms apart (±1 ms).
- LEN=0 word -> timed as exactly 1 tick.
- STOP_i mid-HOLD of a note -> WE_o stays 0, BUSY_o=0 next cycle, no DONE_o. A following START_i restarts at ADR 0.
- Score with no END, C_ADR_W=2 -> plays 4 notes, then DONE_o, IDLE. ADR does not wrap into replay.
- START_i during play and START_i+STOP_i simultaneous in IDLE -> ignored. XARST_i low mid-ISSUE -> all outputs 0 asynchronously.
